// File: rtl/dsp_addsub_pipe.sv
// dsp_addsub_pipe: pipelined WIDTH-bit integer add/subtract built from 16-bit
// adder slices. Stage k resolves slice k and hands its carry to stage k+1, so
// the pipeline depth equals WIDTH/16. Valid/ready handshake on both sides; the
// whole pipe stalls as a unit when the output is held.
// Optional feature: define DSP_ADDSUB_SATURATE_EN to add the in_sat port
// (signed saturation applied in the last stage). Without it results wrap.
module dsp_addsub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
`ifdef DSP_ADDSUB_SATURATE_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int SLICES = WIDTH / 16;
    localparam int LAST   = SLICES - 1;

    if ((WIDTH < 16) || (WIDTH > 64) || ((WIDTH % 16) != 0)) begin : g_width_check
        $error("dsp_addsub_pipe: WIDTH must be a multiple of 16 in the range 16..64");
    end

    // Inputs seen by each stage (stage 0 from the ports, stage k from stage k-1)
    logic             v_in     [SLICES];
    logic [WIDTH-1:0] a_in     [SLICES];
    logic [WIDTH-1:0] b_in     [SLICES];
    logic [WIDTH-1:0] r_in     [SLICES];
    logic             c_in     [SLICES];
    logic             sa_in    [SLICES];
    logic             sb_in    [SLICES];
    logic             sat_in   [SLICES];

    // Combinational results of each stage
    logic [WIDTH-1:0] sum_next [SLICES];
    logic             c_next   [SLICES];

    // Stage registers; the last stage's registers are the output registers
    logic             valid_reg [SLICES];
    logic [WIDTH-1:0] a_reg     [SLICES];
    logic [WIDTH-1:0] b_reg     [SLICES];
    logic [WIDTH-1:0] res_reg   [SLICES];
    logic             carry_reg [SLICES];
    logic             sa_reg    [SLICES];
    logic             sb_reg    [SLICES];
    logic             sat_reg   [SLICES];
    logic             ovf_reg;
    logic             zero_reg;

    logic             advance;
    logic             in_sat_w;
    logic [WIDTH-1:0] raw_last;
    logic [WIDTH-1:0] sat_last;
    logic             ovf_last;

`ifdef DSP_ADDSUB_SATURATE_EN
    assign in_sat_w = in_sat;
`else
    assign in_sat_w = 1'b0;
`endif

    // Whole pipe moves together; no bubble collapse
    assign advance  = !valid_reg[LAST] | out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < SLICES; gi++) begin : g_stage
        logic [16:0] slice_sum;

        if (gi == 0) begin : g_src
            assign v_in[gi]   = in_valid & advance;
            assign a_in[gi]   = in_a;
            assign b_in[gi]   = in_sub ? ~in_b : in_b;
            assign r_in[gi]   = '0;
            assign c_in[gi]   = in_sub;
            assign sa_in[gi]  = in_a[WIDTH-1];
            assign sb_in[gi]  = in_sub ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
            assign sat_in[gi] = in_sat_w;
        end else begin : g_src
            assign v_in[gi]   = valid_reg[gi-1];
            assign a_in[gi]   = a_reg[gi-1];
            assign b_in[gi]   = b_reg[gi-1];
            assign r_in[gi]   = res_reg[gi-1];
            assign c_in[gi]   = carry_reg[gi-1];
            assign sa_in[gi]  = sa_reg[gi-1];
            assign sb_in[gi]  = sb_reg[gi-1];
            assign sat_in[gi] = sat_reg[gi-1];
        end

        // One 16-bit adder slice; bit 16 is the carry into the next slice
        assign slice_sum    = {1'b0, a_in[gi][16*gi +: 16]} + {1'b0, b_in[gi][16*gi +: 16]}
                            + 17'(c_in[gi]);
        assign c_next[gi]   = slice_sum[16];
        // Upper result slices are still zero here, so OR inserts this slice
        assign sum_next[gi] = r_in[gi] | (WIDTH'(slice_sum[15:0]) << (16 * gi));
    end

    // Last stage: signed overflow from the operand sign bits, optional saturation
    assign raw_last = sum_next[LAST];
    assign ovf_last = (sa_in[LAST] == sb_in[LAST]) && (raw_last[WIDTH-1] != sa_in[LAST]);
    assign sat_last = (sat_in[LAST] && ovf_last)
                    ? {sa_in[LAST], {(WIDTH-1){~sa_in[LAST]}}}
                    : raw_last;

    // Pipeline registers: shift on advance, load data only for valid slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SLICES; k++) begin
                valid_reg[k] <= 1'b0;
                a_reg[k]     <= '0;
                b_reg[k]     <= '0;
                res_reg[k]   <= '0;
                carry_reg[k] <= 1'b0;
                sa_reg[k]    <= 1'b0;
                sb_reg[k]    <= 1'b0;
                sat_reg[k]   <= 1'b0;
            end
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < SLICES; k++) begin
                valid_reg[k] <= v_in[k];
                if (v_in[k]) begin
                    a_reg[k]     <= a_in[k];
                    b_reg[k]     <= b_in[k];
                    res_reg[k]   <= (k == LAST) ? sat_last : sum_next[k];
                    carry_reg[k] <= c_next[k];
                    sa_reg[k]    <= sa_in[k];
                    sb_reg[k]    <= sb_in[k];
                    sat_reg[k]   <= sat_in[k];
                end
            end
            if (v_in[LAST]) begin
                ovf_reg  <= ovf_last;
                zero_reg <= (sat_last == '0);
            end
        end
    end

    assign out_valid    = valid_reg[LAST];
    assign out_result   = res_reg[LAST];
    assign out_carry    = carry_reg[LAST];
    assign out_overflow = ovf_reg;
    assign out_zero     = zero_reg;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// tb_dsp_addsub_pipe: self-checking bench for dsp_addsub_pipe. Main instance at
// WIDTH=32; WIDTH=16 and WIDTH=64 instances share the stimulus and are checked
// in the reset/latency scenario. Expected values come from a plain-arithmetic model.
module tb_dsp_addsub_pipe;

`ifdef DSP_ADDSUB_SATURATE_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sub;
    logic        in_sat;
    logic        out_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;

    logic        rdy32, ov32, c32, o32, z32;
    logic [31:0] res32;
    logic        rdy16, ov16, c16, o16, z16;
    logic [15:0] res16;
    logic        rdy64, ov64, c64, o64, z64;
    logic [63:0] res64;

    int checks   = 0;
    int failures = 0;

    dsp_addsub_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_sub(in_sub),
`ifdef DSP_ADDSUB_SATURATE_EN
        .in_sat(in_sat),
`endif
        .out_valid(ov32), .out_ready(out_ready), .out_result(res32),
        .out_carry(c32), .out_overflow(o32), .out_zero(z32)
    );

    dsp_addsub_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_sub(in_sub),
`ifdef DSP_ADDSUB_SATURATE_EN
        .in_sat(in_sat),
`endif
        .out_valid(ov16), .out_ready(out_ready), .out_result(res16),
        .out_carry(c16), .out_overflow(o16), .out_zero(z16)
    );

    dsp_addsub_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef DSP_ADDSUB_SATURATE_EN
        .in_sat(in_sat),
`endif
        .out_valid(ov64), .out_ready(out_ready), .out_result(res64),
        .out_carry(c64), .out_overflow(o64), .out_zero(z64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    // Reference: A+B or A-B modulo 2^w, carry = unsigned carry / no-borrow,
    // overflow by the textbook sign rules, optional saturation to the signed limits.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic sat, input int w);
        exp_t        e;
        logic [64:0] wide;
        logic [63:0] mask;
        logic [63:0] minneg;
        logic        sa, sbit, sr;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        a = a & mask;
        b = b & mask;
        if (sub) begin
            e.r = (a - b) & mask;
            e.c = (a >= b);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            e.r  = wide[63:0] & mask;
            e.c  = wide[w];
        end
        sa   = a[w-1];
        sbit = b[w-1];
        sr   = e.r[w-1];
        e.o  = sub ? ((sa != sbit) && (sr != sa)) : ((sa == sbit) && (sr != sa));
        if (sat && SAT_ON && e.o) begin
            minneg = 64'd1 << (w - 1);
            e.r    = sa ? minneg : (minneg - 64'd1);
        end
        e.z = (e.r == 64'd0);
        return e;
    endfunction

    // Present one operation to the 32-bit unit and wait for its result
    task automatic single_op(input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic sat, output int lat);
        in_a     = {32'd0, a};
        in_b     = {32'd0, b};
        in_sub   = sub;
        in_sat   = sat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!ov32 && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ov32 !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b required 0", ov32);
        end
        checks++;
        if ({res32, c32, o32, z32} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got res=%h c=%b o=%b z=%b required all 0", res32, c32, o32, z32);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy32 !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b required 1", rdy32);
        end
        $display("reset: out_valid=%b in_ready=%b", ov32, rdy32);
    endtask

    logic [31:0] dir_a [8] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_FFFF};
    logic [31:0] dir_b [8] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'h1234_5678, 32'd1};
    logic        dir_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        dir_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] dir_r [8] = '{32'h0000_0000, 32'h8000_0000,
                               SAT_ON ? 32'h7FFF_FFFF : 32'h8000_0000,
                               32'hFFFF_FFFE, 32'h7FFF_FFFF,
                               SAT_ON ? 32'h8000_0000 : 32'h7FFF_FFFF,
                               32'h0000_0000, 32'h0001_0000};
    logic [2:0]  dir_f [8] = '{3'b101, 3'b010, 3'b010, 3'b000, 3'b110, 3'b110, 3'b101, 3'b000};

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 8; i++) begin
            single_op(dir_a[i], dir_b[i], dir_s[i], dir_t[i], lat);
            $display("directed %0d: a=%h b=%h sub=%b sat=%b -> res=%h c=%b o=%b z=%b lat=%0d",
                     i, dir_a[i], dir_b[i], dir_s[i], dir_t[i], res32, c32, o32, z32, lat);
            checks++;
            if (lat !== 2) begin
                failures++; $display("FAIL directed_latency[%0d]: got %0d required 2", i, lat);
            end
            checks++;
            if (res32 !== dir_r[i]) begin
                failures++; $display("FAIL directed_result[%0d]: got %h required %h", i, res32, dir_r[i]);
            end
            checks++;
            if ({c32, o32, z32} !== dir_f[i]) begin
                failures++;
                $display("FAIL directed_flags[%0d]: got c/o/z=%b required %b", i, {c32, o32, z32}, dir_f[i]);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] a, b;
        logic        s, t;
        exp_t        e;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            s = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            e = model({32'd0, a}, {32'd0, b}, s, t, 32);
            single_op(a, b, s, t, lat);
            $display("random %0d: a=%h b=%h sub=%b sat=%b -> res=%h c=%b o=%b z=%b",
                     i, a, b, s, t, res32, c32, o32, z32);
            checks++;
            if ({lat, res32, c32, o32, z32} !== {32'd2, e.r[31:0], e.c, e.o, e.z}) begin
                failures++;
                $display("FAIL random[%0d]: got lat=%0d res=%h c=%b o=%b z=%b required lat=2 res=%h c=%b o=%b z=%b",
                         i, lat, res32, c32, o32, z32, e.r[31:0], e.c, e.o, e.z);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   got   = 0;
        int   first = -1;
        int   last  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid = (cyc < 8);
            in_a     = 64'(cyc);
            in_b     = 64'h0001_FFFF;
            in_sub   = 1'b0;
            in_sat   = 1'b0;
            #1;
            if (in_valid && rdy32) q.push_back(model(64'(cyc), 64'h0001_FFFF, 1'b0, 1'b0, 32));
            @(posedge clk); #1;
            if (ov32) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                $display("stream cyc %0d: res=%h c=%b", cyc, res32, c32);
                checks++;
                if ({res32, c32} !== {e.r[31:0], e.c}) begin
                    failures++;
                    $display("FAIL stream_result[%0d]: got %h/%b required %h/%b", got, res32, c32, e.r[31:0], e.c);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({got, first, last} !== {32'd8, 32'd1, 32'd8}) begin
            failures++;
            $display("FAIL stream_timing: got count=%0d first=%0d last=%0d required 8/1/8", got, first, last);
        end
    endtask

    task automatic test_backpressure();
        exp_t        q[$];
        exp_t        e;
        int          n_in    = 0;
        int          drained = 0;
        int          extra   = 0;
        logic [31:0] held;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_a     = {32'd0, 32'($urandom)};
            in_b     = {32'd0, 32'($urandom)};
            in_sub   = 1'($urandom_range(0, 1));
            in_sat   = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            #1;
            if (rdy32) begin
                q.push_back(model(in_a, in_b, in_sub, in_sat, 32));
                n_in++;
            end
            @(posedge clk); #1;
            if (!rdy32) break;
        end
        held = res32;
        checks++;
        if ({n_in, ov32} !== {32'd2, 1'b1}) begin
            failures++; $display("FAIL bp_fill: got accepted=%0d valid=%b required 2/1", n_in, ov32);
        end
        for (int i = 0; i < 5; i++) begin
            in_a = {32'd0, 32'($urandom)};
            #1;
            $display("stall %0d: in_ready=%b out_valid=%b res=%h", i, rdy32, ov32, res32);
            checks++;
            if ({rdy32, ov32, res32} !== {1'b0, 1'b1, q[0].r[31:0]} || res32 !== held) begin
                failures++;
                $display("FAIL bp_stall[%0d]: got rdy=%b valid=%b res=%h required 0/1/%h", i, rdy32, ov32, res32, q[0].r[31:0]);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (ov32) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    e = q.pop_front();
                    $display("drain %0d: res=%h c=%b o=%b z=%b", drained, res32, c32, o32, z32);
                    checks++;
                    if ({res32, c32, o32, z32} !== {e.r[31:0], e.c, e.o, e.z}) begin
                        failures++;
                        $display("FAIL bp_drain[%0d]: got %h/%b%b%b required %h/%b%b%b",
                                 drained, res32, c32, o32, z32, e.r[31:0], e.c, e.o, e.z);
                    end
                    drained++;
                end
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if ({drained, extra} !== {n_in, 32'd0}) begin
            failures++; $display("FAIL bp_count: got drained=%0d extra=%0d required %0d/0", drained, extra, n_in);
        end
    endtask

    task automatic test_reset_flight();
        int          l16 = 0, l32 = 0, l64 = 0;
        logic [63:0] r16 = '0, r32 = '0, r64 = '0;
        exp_t        e16, e32, e64;
        out_ready = 1'b1;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        $display("async reset: ov16=%b ov32=%b ov64=%b", ov16, ov32, ov64);
        checks++;
        if ({ov16, ov32, ov64} !== 3'b000) begin
            failures++; $display("FAIL rst_valid: got %b required 000", {ov16, ov32, ov64});
        end
        checks++;
        if ({res16, c16, o16, z16, res32, c32, o32, z32, res64, c64, o64, z64} !== '0) begin
            failures++; $display("FAIL rst_outputs: got res16=%h res32=%h res64=%h required 0", res16, res32, res64);
        end
        @(posedge clk); #4;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ov16, ov32, ov64} !== 3'b000) begin
                failures++; $display("FAIL rst_stale[%0d]: got %b required 000", i, {ov16, ov32, ov64});
            end
            @(posedge clk); #1;
        end
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_sub = 1'($urandom_range(0, 1)); in_sat = 1'b0; in_valid = 1'b1;
        e16 = model(in_a, in_b, in_sub, in_sat, 16);
        e32 = model(in_a, in_b, in_sub, in_sat, 32);
        e64 = model(in_a, in_b, in_sub, in_sat, 64);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (ov16 && l16 == 0) begin l16 = n; r16 = {48'd0, res16}; end
            if (ov32 && l32 == 0) begin l32 = n; r32 = {32'd0, res32}; end
            if (ov64 && l64 == 0) begin l64 = n; r64 = res64; end
        end
        $display("post-reset op: lat16=%0d lat32=%0d lat64=%0d", l16, l32, l64);
        checks++;
        if ({l16, l32, l64} !== {32'd1, 32'd2, 32'd4}) begin
            failures++; $display("FAIL rst_latency: got %0d/%0d/%0d required 1/2/4", l16, l32, l64);
        end
        checks++;
        if ({r16, r32, r64} !== {e16.r, e32.r, e64.r}) begin
            failures++;
            $display("FAIL rst_results: got %h/%h/%h required %h/%h/%h", r16, r32, r64, e16.r, e32.r, e64.r);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
